// File: rtl/fifo_param.sv
// Single-clock synchronous FIFO with registered read data, occupancy/threshold flags.
// Optional sticky overflow/underflow flags are built only when FIFO_PARAM_ERR_EN is defined.
module fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  ovf_err,
    output logic                  udf_err
);

    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_CNT    = AE_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_acc, rd_acc;

    // Flags come only from the registered count, never from wr_en/rd_en.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign data_count   = count_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;

    // A write into a full FIFO is allowed only when a read frees a slot on the same edge.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (wr_acc) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is not cleared; stale words are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

`ifdef FIFO_PARAM_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en & ~wr_acc);
        udf_d = udf_q | (rd_en & ~rd_acc);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (default parameters): vector table plus
// hand-written sequences for pointer wrap and mid-stream reset.
module tb_fifo_param;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  data_count;
    logic        ovf_err;
    logic        udf_err;

    int total = 0;
    int bad   = 0;

`ifdef FIFO_PARAM_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    fifo_param dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_count   (data_count),
        .ovf_err      (ovf_err),
        .udf_err      (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        wr;
        logic        rd;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_rvalid;
        int          exp_cnt;
        logic        exp_ovf;
        logic        exp_udf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic w, logic r, logic [31:0] wd,
                                logic [31:0] erd, logic ev, int ec, logic eo, logic eu);
        vec_t v;
        v.name = n; v.wr = w; v.rd = r; v.wdata = wd;
        v.exp_rdata = erd; v.exp_rvalid = ev; v.exp_cnt = ec;
        v.exp_ovf = eo & ERR_ON; v.exp_udf = eu & ERR_ON;
        vecs.push_back(v);
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_flags(string n, int cnt);
        chk({n, ".count"}, 32'(data_count), 32'(cnt));
        chk({n, ".full"}, 32'(full), 32'(cnt == 8));
        chk({n, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({n, ".afull"}, 32'(almost_full), 32'(cnt >= 6));
        chk({n, ".aempty"}, 32'(almost_empty), 32'(cnt <= 1));
    endtask

    task automatic step(logic w, logic r, logic [31:0] wd);
        wr_en = w; rd_en = r; wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] model_q[$];
    logic [31:0] exp_word;
    logic        w, r, racc;

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_flags("reset", 0);
        chk("reset.rd_data", rd_data, 32'h0);
        chk("reset.rd_valid", 32'(rd_valid), 32'h0);
        chk("reset.ovf", 32'(ovf_err), 32'h0);
        chk("reset.udf", 32'(udf_err), 32'h0);
        reset = 1'b0;

        for (int k = 1; k <= 8; k++) add("fill_a", 1, 0, 32'h11 * k, 32'h0, 0, k, 0, 0);
        for (int k = 1; k <= 8; k++) add("drain_a", 0, 1, 32'h0, 32'h11 * k, 1, 8 - k, 0, 0);
        for (int k = 1; k <= 8; k++) add("fill_b", 1, 0, 32'h11 * k, 32'h88, 0, k, 0, 0);
        add("wr_full_rej", 1, 0, 32'hEE, 32'h88, 0, 8, 1, 0);
        add("rw_full",     1, 1, 32'h99, 32'h11, 1, 8, 1, 0);
        for (int k = 2; k <= 8; k++) add("drain_b", 0, 1, 32'h0, 32'h11 * k, 1, 9 - k, 1, 0);
        add("drain_b_last", 0, 1, 32'h0,  32'h99, 1, 0, 1, 0);
        add("rd_empty",     0, 1, 32'h0,  32'h99, 0, 0, 1, 1);
        add("idle",         0, 0, 32'h0,  32'h99, 0, 0, 1, 1);
        add("rw_empty",     1, 1, 32'hAB, 32'h99, 0, 1, 1, 1);
        add("rd_one",       0, 1, 32'h0,  32'hAB, 1, 0, 1, 1);

        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].rd, vecs[i].wdata);
            chk({vecs[i].name, ".rd_data"}, rd_data, vecs[i].exp_rdata);
            chk({vecs[i].name, ".rd_valid"}, 32'(rd_valid), 32'(vecs[i].exp_rvalid));
            chk({vecs[i].name, ".ovf"}, 32'(ovf_err), 32'(vecs[i].exp_ovf));
            chk({vecs[i].name, ".udf"}, 32'(udf_err), 32'(vecs[i].exp_udf));
            chk_flags(vecs[i].name, vecs[i].exp_cnt);
        end

        // Mid-stream reset with both requests asserted.
        for (int k = 0; k < 5; k++) step(1, 0, 32'hC0 + k);
        chk_flags("pre_reset", 5);
        reset = 1'b1;
        step(1, 1, 32'hDD);
        reset = 1'b0;
        chk_flags("mid_reset", 0);
        chk("mid_reset.rd_valid", 32'(rd_valid), 32'h0);
        chk("mid_reset.rd_data", rd_data, 32'h0);
        chk("mid_reset.ovf", 32'(ovf_err), 32'h0);
        chk("mid_reset.udf", 32'(udf_err), 32'h0);
        step(0, 1, 32'h0);
        chk("post_reset_rd.rd_valid", 32'(rd_valid), 32'h0);
        chk("post_reset_rd.rd_data", rd_data, 32'h0);
        chk_flags("post_reset_rd", 0);

        // Interleaved 12 writes / 12 reads against a queue model; wraps both pointers.
        reset = 1'b1;
        step(0, 0, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            w = (i < 12);
            r = (i < 12) ? i[0] : 1'b1;
            racc = r && (model_q.size() > 0);
            exp_word = 32'h0;
            if (racc) exp_word = model_q.pop_front();
            step(w, r, 32'hA0 + i);
            if (w) model_q.push_back(32'hA0 + i);
            chk("wrap.rd_valid", 32'(rd_valid), 32'(racc));
            if (racc) chk("wrap.rd_data", rd_data, exp_word);
            chk("wrap.count", 32'(data_count), 32'(model_q.size()));
        end
        step(0, 0, 32'h0);
        chk_flags("wrap_end", 0);
        chk("wrap_end.rd_data", rd_data, 32'hAB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
